// File: rtl/snes_frame_sync_if.sv
// Signal bundle between the SNES-side frame sync controller and its environment.
// The slave modport is the controller's view; master is the driver/observer side.
interface snes_frame_sync_if #(
  parameter int CNT_W = 20
) ();
  logic             enable;
  logic [7:0]       ys_line;
  logic             snes_refresh;
  logic             hdmi_first_line_async;
  logic             pause_snes;
  logic [1:0]       sync_state;
  logic [CNT_W-1:0] wait_cycles;
  logic             wait_valid;
  logic [7:0]       timeout_count;
  logic             locked;

  modport master (
    output enable, ys_line, snes_refresh, hdmi_first_line_async,
    input  pause_snes, sync_state, wait_cycles, wait_valid, timeout_count, locked
  );

  modport slave (
    input  enable, ys_line, snes_refresh, hdmi_first_line_async,
    output pause_snes, sync_state, wait_cycles, wait_valid, timeout_count, locked
  );
endinterface

// File: rtl/snes_frame_sync_ctrl.sv
// Once-per-frame SNES pause sequencer: holds the core for an even number of clk
// cycles until the HDMI first-line edge arrives, bounded by a timeout.
module snes_frame_sync_ctrl #(
  parameter int SYNC_LINE      = 2,
  parameter int REARM_LINE     = 200,
  parameter int TIMEOUT_CYCLES = 400000,
  parameter int CNT_W          = 20,
  parameter int LOCK_FRAMES    = 4
) (
  input  logic                 clk,
  input  logic                 resetn,
  snes_frame_sync_if.slave     bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_PAUSED = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]       SYNC_Y       = 8'(SYNC_LINE);
  localparam logic [7:0]       REARM_Y      = 8'(REARM_LINE);
  localparam logic [7:0]       LOCK_TARGET  = 8'(LOCK_FRAMES);

  state_t           state_r, state_s;
  logic             sync1_r, sync2_r, sync3_r;
  logic             hs_pulse_s;
  logic             seen_r, seen_s;
  logic             parity_r, parity_s;
  logic [CNT_W-1:0] cnt_r, cnt_s, cnt_inc_s;
  logic             pause_r;
  logic [CNT_W-1:0] wait_cycles_r, wait_cycles_s;
  logic             wait_valid_r, wait_valid_s;
  logic [7:0]       timeout_count_r, timeout_count_s;
  logic             locked_r, locked_s;
  logic [7:0]       streak_r, streak_s, streak_inc_s;
  logic             sync_hit_s, tmo_hit_s, release_s;

  assign hs_pulse_s   = sync2_r & ~sync3_r;
  assign cnt_inc_s    = (&cnt_r) ? cnt_r : (cnt_r + CNT_W'(1));
  assign streak_inc_s = (streak_r >= LOCK_TARGET) ? streak_r : (streak_r + 8'd1);
  assign sync_hit_s   = seen_r | hs_pulse_s;
  assign tmo_hit_s    = (cnt_r == TIMEOUT_LAST);
  // Release is only allowed on odd counter values, so every pause is even-length.
  assign release_s    = (state_r == ST_PAUSED) && parity_r &&
                        (sync_hit_s || tmo_hit_s || !bus.enable);

  // Two-flop synchroniser for the clk_pixel level plus an edge-detect stage.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      sync3_r <= 1'b0;
    end else begin
      sync1_r <= bus.hdmi_first_line_async;
      sync2_r <= sync1_r;
      sync3_r <= sync2_r;
    end
  end

  // Next-state, pause bookkeeping and lock/statistics update.
  always_comb begin
    state_s         = state_r;
    seen_s          = seen_r;
    parity_s        = parity_r;
    cnt_s           = cnt_r;
    wait_cycles_s   = wait_cycles_r;
    wait_valid_s    = 1'b0;
    timeout_count_s = timeout_count_r;
    locked_s        = locked_r;
    streak_s        = streak_r;

    case (state_r)
      ST_IDLE: begin
        if (bus.enable) begin
          state_s = ST_ARMED;
        end else begin
          locked_s = 1'b0;
          streak_s = 8'd0;
        end
      end
      ST_ARMED: begin
        if (!bus.enable) begin
          state_s  = ST_IDLE;
          locked_s = 1'b0;
          streak_s = 8'd0;
        end else if ((bus.ys_line == SYNC_Y) && bus.snes_refresh) begin
          state_s  = ST_PAUSED;
          cnt_s    = '0;
          parity_s = 1'b0;
          seen_s   = hs_pulse_s;
        end else begin
          state_s = ST_ARMED;
        end
      end
      ST_PAUSED: begin
        if (release_s) begin
          wait_cycles_s = cnt_inc_s;
          wait_valid_s  = 1'b1;
          state_s       = bus.enable ? ST_DONE : ST_IDLE;
          if (sync_hit_s) begin
            streak_s = streak_inc_s;
            if (streak_inc_s >= LOCK_TARGET) begin
              locked_s = 1'b1;
            end else begin
              locked_s = locked_r;
            end
          end else if (tmo_hit_s) begin
            timeout_count_s = (&timeout_count_r) ? timeout_count_r : (timeout_count_r + 8'd1);
            locked_s        = 1'b0;
            streak_s        = 8'd0;
          end else begin
            locked_s = 1'b0;
            streak_s = 8'd0;
          end
        end else begin
          parity_s = ~parity_r;
          cnt_s    = cnt_inc_s;
          seen_s   = sync_hit_s;
        end
      end
      ST_DONE: begin
        if (!bus.enable) begin
          state_s  = ST_IDLE;
          locked_s = 1'b0;
          streak_s = 8'd0;
        end else if (bus.ys_line == REARM_Y) begin
          state_s = ST_ARMED;
        end else begin
          state_s = ST_DONE;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Controller state and registered outputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r         <= ST_IDLE;
      seen_r          <= 1'b0;
      parity_r        <= 1'b0;
      cnt_r           <= '0;
      pause_r         <= 1'b0;
      wait_cycles_r   <= '0;
      wait_valid_r    <= 1'b0;
      timeout_count_r <= 8'd0;
      locked_r        <= 1'b0;
      streak_r        <= 8'd0;
    end else begin
      state_r         <= state_s;
      seen_r          <= seen_s;
      parity_r        <= parity_s;
      cnt_r           <= cnt_s;
      pause_r         <= (state_s == ST_PAUSED);
      wait_cycles_r   <= wait_cycles_s;
      wait_valid_r    <= wait_valid_s;
      timeout_count_r <= timeout_count_s;
      locked_r        <= locked_s;
      streak_r        <= streak_s;
    end
  end

  assign bus.pause_snes    = pause_r;
  assign bus.sync_state    = state_r;
  assign bus.wait_cycles   = wait_cycles_r;
  assign bus.wait_valid    = wait_valid_r;
  assign bus.timeout_count = timeout_count_r;
  assign bus.locked        = locked_r;

endmodule

// File: tb/tb_snes_frame_sync_ctrl.sv
// Bench for snes_frame_sync_ctrl: vector table, directed frame sequences and a
// random phase checked against a cycle-count based reference model.
module tb_snes_frame_sync_ctrl;
  localparam int TO    = 1000;
  localparam int CW    = 20;
  localparam int LOCK  = 4;
  localparam int SYNC  = 2;
  localparam int REARM = 200;
  localparam int M_IDLE = 0, M_ARMED = 1, M_PAUSED = 2, M_DONE = 3;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  snes_frame_sync_if #(.CNT_W(CW)) bus ();

  snes_frame_sync_ctrl #(
    .SYNC_LINE(SYNC), .REARM_LINE(REARM), .TIMEOUT_CYCLES(TO),
    .CNT_W(CW), .LOCK_FRAMES(LOCK)
  ) u_dut (
    .clk(clk), .resetn(resetn), .bus(bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: pause length is tracked as elapsed clock edges since trigger.
  int m_k = 0, m_mode = 0, m_start = 0, m_seen = 0, m_streak = 0, m_locked = 0;
  int m_to = 0, m_wait = 0, m_wv = 0, m_pause = 0;
  int h0 = 0, h1 = 0, h2 = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic model_step();
    int hs, n, hit;
    m_k++;
    if (!resetn) begin
      m_mode = M_IDLE; m_pause = 0; m_wait = 0; m_wv = 0; m_to = 0;
      m_locked = 0; m_streak = 0; m_seen = 0; h0 = 0; h1 = 0; h2 = 0;
    end else begin
      hs = (h1 == 1 && h2 == 0) ? 1 : 0;
      h2 = h1; h1 = h0; h0 = int'(bus.hdmi_first_line_async);
      m_wv = 0;
      case (m_mode)
        M_IDLE: begin
          if (bus.enable) m_mode = M_ARMED;
          else begin m_locked = 0; m_streak = 0; end
        end
        M_ARMED: begin
          if (!bus.enable) begin m_mode = M_IDLE; m_locked = 0; m_streak = 0; end
          else if (int'(bus.ys_line) == SYNC && bus.snes_refresh) begin
            m_mode = M_PAUSED; m_start = m_k; m_seen = hs;
          end
        end
        M_PAUSED: begin
          n = m_k - m_start;
          hit = m_seen | hs;
          if (n % 2 == 0 && (hit != 0 || n == TO || !bus.enable)) begin
            m_wait = n; m_wv = 1;
            if (hit != 0) begin
              if (m_streak < LOCK) m_streak++;
              if (m_streak >= LOCK) m_locked = 1;
            end else begin
              if (n == TO && m_to < 255) m_to++;
              m_locked = 0; m_streak = 0;
            end
            m_mode = bus.enable ? M_DONE : M_IDLE;
          end else begin
            m_seen = hit;
          end
        end
        default: begin
          if (!bus.enable) begin m_mode = M_IDLE; m_locked = 0; m_streak = 0; end
          else if (int'(bus.ys_line) == REARM) m_mode = M_ARMED;
        end
      endcase
      m_pause = (m_mode == M_PAUSED) ? 1 : 0;
    end
  endtask

  function automatic logic [32:0] model_pack();
    logic [31:0] p, s, w, l, t, c;
    p = m_pause; s = m_mode; w = m_wv; l = m_locked; t = m_to; c = m_wait;
    return {p[0], s[1:0], w[0], l[0], t[7:0], c[19:0]};
  endfunction

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("model", 64'({bus.pause_snes, bus.sync_state, bus.wait_valid, bus.locked,
                       bus.timeout_count, bus.wait_cycles}), 64'(model_pack()));
  endtask

  task automatic drive(input logic en, input logic [7:0] ys, input logic rf, input logic a);
    bus.enable = en; bus.ys_line = ys; bus.snes_refresh = rf; bus.hdmi_first_line_async = a;
  endtask

  task automatic trigger(input string nm);
    drive(1'b1, 8'(SYNC), 1'b1, bus.hdmi_first_line_async);
    cycle();
    chk({nm, "_trig_pause"}, 64'(bus.pause_snes), 64'(1));
    chk({nm, "_trig_state"}, 64'(bus.sync_state), 64'(2));
    drive(1'b1, 8'd10, 1'b0, bus.hdmi_first_line_async);
  endtask

  task automatic wait_release(input string nm, output int got);
    got = -1;
    for (int i = 0; i < TO + 20; i++) begin
      cycle();
      if (bus.wait_valid === 1'b1) begin
        got = int'(bus.wait_cycles);
        break;
      end
    end
    chk({nm, "_release_seen"}, 64'(got >= 0), 64'(1));
  endtask

  // k<0 means no HDMI edge during the pause; poke raises an edge while DONE.
  task automatic do_frame(input string nm, input int k, input int exp, input bit poke, output int got);
    bus.hdmi_first_line_async = 1'b0;
    trigger(nm);
    if (k >= 0) begin
      repeat (k) cycle();
      bus.hdmi_first_line_async = 1'b1;
    end
    wait_release(nm, got);
    chk({nm, "_wait"}, 64'(got), 64'(exp));
    cycle();
    chk({nm, "_wv_once"}, 64'(bus.wait_valid), 64'(0));
    if (poke) begin
      bus.hdmi_first_line_async = 1'b0;
      repeat (3) cycle();
      bus.hdmi_first_line_async = 1'b1;
      for (int i = 0; i < 6; i++) begin
        cycle();
        chk({nm, "_done_state"}, 64'(bus.sync_state), 64'(3));
        chk({nm, "_done_pause"}, 64'(bus.pause_snes), 64'(0));
      end
    end
    drive(1'b1, 8'(REARM), 1'b0, bus.hdmi_first_line_async);
    cycle();
    chk({nm, "_rearm"}, 64'(bus.sync_state), 64'(1));
    drive(1'b1, 8'd10, 1'b0, 1'b0);
    repeat (3) cycle();
  endtask

  typedef struct {
    logic rstn; logic en; logic [7:0] ys; logic rf; logic a;
    logic [1:0] st; logic ps; logic wv; logic [19:0] wt; logic [7:0] to; logic lk;
  } vec_t;
  vec_t tbl [14];

  int got;

  initial begin
    tbl[0]  = '{1'b0, 1'b0, 8'd0,   1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 20'd0, 8'd0, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 8'd0,   1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 20'd0, 8'd0, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 8'd2,   1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 20'd0, 8'd0, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 8'd5,   1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 20'd0, 8'd0, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 8'd2,   1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 20'd0, 8'd0, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 8'd0,   1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 20'd0, 8'd0, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 8'd0,   1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 20'd0, 8'd0, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 8'd0,   1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 20'd0, 8'd0, 1'b0};
    tbl[8]  = '{1'b1, 1'b1, 8'd2,   1'b1, 1'b1, 2'd2, 1'b1, 1'b0, 20'd0, 8'd0, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 8'd2,   1'b1, 1'b1, 2'd2, 1'b1, 1'b0, 20'd0, 8'd0, 1'b0};
    tbl[10] = '{1'b1, 1'b1, 8'd2,   1'b1, 1'b1, 2'd3, 1'b0, 1'b1, 20'd2, 8'd0, 1'b0};
    tbl[11] = '{1'b1, 1'b1, 8'd3,   1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 20'd2, 8'd0, 1'b0};
    tbl[12] = '{1'b1, 1'b1, 8'd200, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 20'd2, 8'd0, 1'b0};
    tbl[13] = '{1'b1, 1'b0, 8'd200, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 20'd2, 8'd0, 1'b0};

    resetn = 1'b0;
    drive(1'b0, 8'd0, 1'b0, 1'b0);
    for (int i = 0; i < 14; i++) begin
      resetn = tbl[i].rstn;
      drive(tbl[i].en, tbl[i].ys, tbl[i].rf, tbl[i].a);
      cycle();
      chk($sformatf("vec%0d_state", i), 64'(bus.sync_state),    64'(tbl[i].st));
      chk($sformatf("vec%0d_pause", i), 64'(bus.pause_snes),    64'(tbl[i].ps));
      chk($sformatf("vec%0d_wv", i),    64'(bus.wait_valid),    64'(tbl[i].wv));
      chk($sformatf("vec%0d_wait", i),  64'(bus.wait_cycles),   64'(tbl[i].wt));
      chk($sformatf("vec%0d_to", i),    64'(bus.timeout_count), 64'(tbl[i].to));
      chk($sformatf("vec%0d_lock", i),  64'(bus.locked),        64'(tbl[i].lk));
    end

    drive(1'b1, 8'd10, 1'b0, 1'b0);
    cycle();
    chk("arm", 64'(bus.sync_state), 64'(1));
    repeat (3) cycle();

    do_frame("tmo1", -1, TO, 1'b0, got);
    chk("tmo1_count", 64'(bus.timeout_count), 64'(1));
    chk("tmo1_lock", 64'(bus.locked), 64'(0));

    do_frame("edge100", 100, 104, 1'b0, got);
    chk("edge100_range", 64'(got >= 102 && got <= 106 && got % 2 == 0), 64'(1));
    do_frame("even8", 5, 8, 1'b0, got);
    do_frame("odd9", 6, 10, 1'b0, got);
    chk("lock_after3", 64'(bus.locked), 64'(0));
    do_frame("fourth", 20, 24, 1'b0, got);
    chk("lock_after4", 64'(bus.locked), 64'(1));

    // Enable dropped while the counter reads 7.
    trigger("dis");
    repeat (7) cycle();
    drive(1'b0, 8'd10, 1'b0, 1'b0);
    cycle();
    chk("dis_wv", 64'(bus.wait_valid), 64'(1));
    chk("dis_wait", 64'(bus.wait_cycles), 64'(8));
    chk("dis_state", 64'(bus.sync_state), 64'(0));
    chk("dis_pause", 64'(bus.pause_snes), 64'(0));
    chk("dis_lock", 64'(bus.locked), 64'(0));
    chk("dis_to", 64'(bus.timeout_count), 64'(1));
    drive(1'b1, 8'd10, 1'b0, 1'b0);
    cycle();
    repeat (3) cycle();

    do_frame("tmo2", -1, TO, 1'b0, got);
    chk("tmo2_count", 64'(bus.timeout_count), 64'(2));
    chk("tmo2_lock", 64'(bus.locked), 64'(0));
    do_frame("tie", TO - 3, TO, 1'b0, got);
    chk("tie_to", 64'(bus.timeout_count), 64'(2));
    do_frame("donepoke", 10, 14, 1'b1, got);

    // Reset asserted in the middle of a pause.
    trigger("rst");
    repeat (5) cycle();
    resetn = 1'b0;
    cycle();
    chk("rst_pause", 64'(bus.pause_snes), 64'(0));
    chk("rst_state", 64'(bus.sync_state), 64'(0));
    chk("rst_wait", 64'(bus.wait_cycles), 64'(0));
    chk("rst_wv", 64'(bus.wait_valid), 64'(0));
    chk("rst_to", 64'(bus.timeout_count), 64'(0));
    chk("rst_lock", 64'(bus.locked), 64'(0));
    resetn = 1'b1;

    for (int i = 0; i < 20000; i++) begin
      int r;
      resetn = ($urandom_range(0, 999) != 0);
      bus.enable = ($urandom_range(0, 49) != 0);
      r = $urandom_range(0, 9);
      if (r < 3) bus.ys_line = 8'(SYNC);
      else if (r == 3) bus.ys_line = 8'(REARM);
      else bus.ys_line = 8'($urandom_range(0, 255));
      bus.snes_refresh = 1'($urandom_range(0, 1));
      if ($urandom_range(0, (i < 10000) ? 7 : 400) == 0)
        bus.hdmi_first_line_async = ~bus.hdmi_first_line_async;
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
